wb_stage_reg: RTL and testbench

M-to-W pipeline register for the pipelined Y86 core. Captures the memory-stage result each cycle and drives the W_* interface consumed by the register file's writeback port. Derives destination register IDs (dstE/dstM) for forwarding, applies stall/bubble control, freezes on an exception status, and counts retired instructions.

---
 rtl/wb_stage_reg.sv | 135 +++++++++++++
 tb/tb_wb_stage_reg.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/wb_stage_reg.sv
// wb_stage_reg: M-to-W pipeline register for the pipelined Y86 core.
// Latches the memory-stage result into the W_* bundle feeding register-file
// writeback. It also derives the dstE/dstM destinations, applies stall and
// bubble control, freezes on a non-AOK status and counts retired instructions.
module wb_stage_reg #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       M_stat,
    input  logic [2:0]       m_stat,
    input  logic [3:0]       M_icode,
    input  logic [3:0]       M_rA,
    input  logic [3:0]       M_rB,
    input  logic             M_Cnd,
    input  logic [63:0]      M_valE,
    input  logic [63:0]      m_valM,
    input  logic             W_stall,
    input  logic             W_bubble,
    output logic [2:0]       W_stat,
    output logic [3:0]       W_icode,
    output logic [3:0]       W_rA,
    output logic [3:0]       W_rB,
    output logic             W_Cnd,
    output logic [63:0]      W_valE,
    output logic [63:0]      W_valM,
    output logic [3:0]       W_dstE,
    output logic [3:0]       W_dstM,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        STAT_AOK = 3'd1,
        STAT_HLT = 3'd2,
        STAT_ADR = 3'd3,
        STAT_INS = 3'd4
    } stat_t;

    typedef enum logic [3:0] {
        I_HALT   = 4'h0,
        I_NOP    = 4'h1,
        I_RRMOVQ = 4'h2,
        I_IRMOVQ = 4'h3,
        I_RMMOVQ = 4'h4,
        I_MRMOVQ = 4'h5,
        I_OPQ    = 4'h6,
        I_JXX    = 4'h7,
        I_CALL   = 4'h8,
        I_RET    = 4'h9,
        I_PUSHQ  = 4'hA,
        I_POPQ   = 4'hB
    } icode_t;

    localparam logic [3:0] REG_NONE = 4'hF;
    localparam logic [3:0] REG_RSP  = 4'h4;

    // M_stat is superseded by m_stat, which already folds in memory faults.
    logic unused_m_stat;
    assign unused_m_stat = ^M_stat;

    logic m_fault;
    logic m_aok;
    logic m_counts;

    // Classify the incoming status and whether this instruction retires.
    always_comb begin
        m_fault  = (m_stat == STAT_ADR) || (m_stat == STAT_INS);
        m_aok    = (m_stat == STAT_AOK);
        m_counts = m_aok && (M_icode != I_HALT) && (M_icode != I_NOP);
    end

    // Pipeline register: reset, then hold (halted or stall), bubble, capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            W_stat  <= STAT_AOK;
            W_icode <= I_NOP;
            W_rA    <= REG_NONE;
            W_rB    <= REG_NONE;
            W_Cnd   <= 1'b0;
            W_valE  <= '0;
            W_valM  <= '0;
            halted  <= 1'b0;
            retired <= '0;
        end else if (!halted && !W_stall) begin
            if (W_bubble) begin
                W_stat  <= STAT_AOK;
                W_icode <= I_NOP;
                W_rA    <= REG_NONE;
                W_rB    <= REG_NONE;
                W_Cnd   <= 1'b0;
                W_valE  <= '0;
                W_valM  <= '0;
            end else begin
                W_stat <= m_stat;
                W_Cnd  <= M_Cnd;
                W_valE <= M_valE;
                W_valM <= m_valM;
                // A faulting instruction keeps its status but must not write back.
                if (m_fault) begin
                    W_icode <= I_NOP;
                    W_rA    <= REG_NONE;
                    W_rB    <= REG_NONE;
                end else begin
                    W_icode <= M_icode;
                    W_rA    <= M_rA;
                    W_rB    <= M_rB;
                end
                if (!m_aok) begin
                    halted <= 1'b1;
                end
                if (m_counts) begin
                    retired <= retired + CNT_W'(1);
                end
            end
        end
    end

    // Writeback destinations decoded from the latched W registers only.
    always_comb begin
        W_dstE = REG_NONE;
        W_dstM = REG_NONE;
        case (W_icode)
            I_IRMOVQ, I_OPQ:                W_dstE = W_rB;
            I_RRMOVQ:                       W_dstE = W_Cnd ? W_rB : REG_NONE;
            I_CALL, I_RET, I_PUSHQ, I_POPQ: W_dstE = REG_RSP;
            default:                        W_dstE = REG_NONE;
        endcase
        case (W_icode)
            I_MRMOVQ, I_POPQ: W_dstM = W_rA;
            default:          W_dstM = REG_NONE;
        endcase
    end

endmodule

// File: tb/tb_wb_stage_reg.sv
// tb_wb_stage_reg: directed vectors with hand-computed W-stage expectations.
// The stimulus side queues the expected W snapshot per cycle; the monitor
// pops one snapshot after each rising edge and compares all outputs.
module tb_wb_stage_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  M_stat, m_stat;
    logic [3:0]  M_icode, M_rA, M_rB;
    logic        M_Cnd;
    logic [63:0] M_valE, m_valM;
    logic        W_stall, W_bubble;
    logic [2:0]  W_stat;
    logic [3:0]  W_icode, W_rA, W_rB;
    logic        W_Cnd;
    logic [63:0] W_valE, W_valM;
    logic [3:0]  W_dstE, W_dstM;
    logic        halted;
    logic [3:0]  retired;

    wb_stage_reg #(.CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .M_stat(M_stat), .m_stat(m_stat), .M_icode(M_icode),
        .M_rA(M_rA), .M_rB(M_rB), .M_Cnd(M_Cnd),
        .M_valE(M_valE), .m_valM(m_valM),
        .W_stall(W_stall), .W_bubble(W_bubble),
        .W_stat(W_stat), .W_icode(W_icode), .W_rA(W_rA), .W_rB(W_rB),
        .W_Cnd(W_Cnd), .W_valE(W_valE), .W_valM(W_valM),
        .W_dstE(W_dstE), .W_dstM(W_dstM),
        .halted(halted), .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  stat;
        logic [3:0]  icode;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic        cnd;
        logic [63:0] vale;
        logic [63:0] valm;
        logic [3:0]  dste;
        logic [3:0]  dstm;
        logic        hlt;
        logic [3:0]  ret;
    } wb_t;

    wb_t   exp_q[$];
    string name_q[$];
    int    vectors     = 0;
    int    miscompares = 0;

    function automatic wb_t mk(input logic [2:0] st, input logic [3:0] ic,
                               input logic [3:0] ra, input logic [3:0] rb,
                               input logic c, input logic [63:0] ve,
                               input logic [63:0] vm, input logic [3:0] de,
                               input logic [3:0] dm, input logic h,
                               input logic [3:0] rt);
        wb_t w;
        w.stat = st; w.icode = ic; w.ra = ra; w.rb = rb; w.cnd = c;
        w.vale = ve; w.valm = vm; w.dste = de; w.dstm = dm; w.hlt = h;
        w.ret = rt;
        return w;
    endfunction

    task automatic step(input string nm, input logic r, input logic stl,
                        input logic bub, input logic [2:0] mst,
                        input logic [2:0] mem_st, input logic [3:0] ic,
                        input logic [3:0] ra, input logic [3:0] rb,
                        input logic c, input logic [63:0] ve,
                        input logic [63:0] vm, input wb_t e);
        @(negedge clk);
        rst = r; W_stall = stl; W_bubble = bub;
        M_stat = mst; m_stat = mem_st; M_icode = ic; M_rA = ra; M_rB = rb;
        M_Cnd = c; M_valE = ve; m_valM = vm;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Monitor: one snapshot per rising edge, sampled just after the edge.
    always @(posedge clk) begin
        wb_t   e, a;
        string n;
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            a = '{stat: W_stat, icode: W_icode, ra: W_rA, rb: W_rB, cnd: W_Cnd,
                  vale: W_valE, valm: W_valM, dste: W_dstE, dstm: W_dstM,
                  hlt: halted, ret: retired};
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL %s: got stat=%0d icode=%h rA=%h rB=%h cnd=%b valE=%h valM=%h dstE=%h dstM=%h halted=%b retired=%0d, expected stat=%0d icode=%h rA=%h rB=%h cnd=%b valE=%h valM=%h dstE=%h dstM=%h halted=%b retired=%0d",
                         n, a.stat, a.icode, a.ra, a.rb, a.cnd, a.vale, a.valm,
                         a.dste, a.dstm, a.hlt, a.ret,
                         e.stat, e.icode, e.ra, e.rb, e.cnd, e.vale, e.valm,
                         e.dste, e.dstm, e.hlt, e.ret);
            end
        end
    end

    initial begin
        // name, rst, stall, bubble, M_stat, m_stat, icode, rA, rB, Cnd, valE, valM
        step("reset", 1, 0, 0, 1, 1, 4'h1, 4'hF, 4'hF, 0, 64'h0, 64'h0,
             mk(1, 4'h1, 4'hF, 4'hF, 0, 64'h0, 64'h0, 4'hF, 4'hF, 0, 0));
        step("opq", 0, 0, 0, 1, 1, 4'h6, 4'h1, 4'h3, 0, 64'h2A, 64'h0,
             mk(1, 4'h6, 4'h1, 4'h3, 0, 64'h2A, 64'h0, 4'h3, 4'hF, 0, 1));
        step("cmov_cnd0", 0, 0, 0, 1, 1, 4'h2, 4'h1, 4'h5, 0, 64'h7, 64'h0,
             mk(1, 4'h2, 4'h1, 4'h5, 0, 64'h7, 64'h0, 4'hF, 4'hF, 0, 2));
        step("cmov_cnd1", 0, 0, 0, 1, 1, 4'h2, 4'h1, 4'h5, 1, 64'h7, 64'h0,
             mk(1, 4'h2, 4'h1, 4'h5, 1, 64'h7, 64'h0, 4'h5, 4'hF, 0, 3));
        step("popq", 0, 0, 0, 1, 1, 4'hB, 4'h2, 4'hF, 0, 64'h108, 64'h77,
             mk(1, 4'hB, 4'h2, 4'hF, 0, 64'h108, 64'h77, 4'h4, 4'h2, 0, 4));
        step("stall_and_bubble", 0, 1, 1, 1, 1, 4'h3, 4'hF, 4'h7, 0, 64'h99, 64'h0,
             mk(1, 4'hB, 4'h2, 4'hF, 0, 64'h108, 64'h77, 4'h4, 4'h2, 0, 4));
        step("bubble", 0, 0, 1, 1, 1, 4'h3, 4'hF, 4'h7, 0, 64'h99, 64'h0,
             mk(1, 4'h1, 4'hF, 4'hF, 0, 64'h0, 64'h0, 4'hF, 4'hF, 0, 4));
        step("nop_capture", 0, 0, 0, 1, 1, 4'h1, 4'hF, 4'hF, 0, 64'h5, 64'h0,
             mk(1, 4'h1, 4'hF, 4'hF, 0, 64'h5, 64'h0, 4'hF, 4'hF, 0, 4));
        step("mrmovq_adr", 0, 0, 0, 1, 3, 4'h5, 4'h1, 4'h2, 1, 64'h10, 64'h55,
             mk(3, 4'h1, 4'hF, 4'hF, 1, 64'h10, 64'h55, 4'hF, 4'hF, 1, 4));
        step("halted_ignores_bubble", 0, 0, 1, 1, 1, 4'h6, 4'h1, 4'h3, 0, 64'h2A, 64'h0,
             mk(3, 4'h1, 4'hF, 4'hF, 1, 64'h10, 64'h55, 4'hF, 4'hF, 1, 4));
        step("halted_ignores_input", 0, 0, 0, 1, 1, 4'h6, 4'h1, 4'h3, 0, 64'h2A, 64'h0,
             mk(3, 4'h1, 4'hF, 4'hF, 1, 64'h10, 64'h55, 4'hF, 4'hF, 1, 4));
        step("reset_while_halted", 1, 1, 0, 1, 1, 4'h6, 4'h1, 4'h3, 0, 64'h2A, 64'h0,
             mk(1, 4'h1, 4'hF, 4'hF, 0, 64'h0, 64'h0, 4'hF, 4'hF, 0, 0));
        // Fifteen irmovq captures bring the 4-bit counter to its maximum.
        for (int i = 0; i < 15; i++) begin
            step("irmovq_fill", 0, 0, 0, 1, 1, 4'h3, 4'hF, 4'(i), 0, 64'(i), 64'h0,
                 mk(1, 4'h3, 4'hF, 4'(i), 0, 64'(i), 64'h0, 4'(i), 4'hF, 0, 4'(i + 1)));
        end
        step("call_wrap", 0, 0, 0, 1, 1, 4'h8, 4'hF, 4'hF, 0, 64'h200, 64'h0,
             mk(1, 4'h8, 4'hF, 4'hF, 0, 64'h200, 64'h0, 4'h4, 4'hF, 0, 0));
        step("halt_hlt", 0, 0, 0, 2, 2, 4'h0, 4'hF, 4'hF, 0, 64'h0, 64'h0,
             mk(2, 4'h0, 4'hF, 4'hF, 0, 64'h0, 64'h0, 4'hF, 4'hF, 1, 0));
        step("halted_holds", 0, 0, 0, 4, 4, 4'h9, 4'hF, 4'hF, 0, 64'h300, 64'h0,
             mk(2, 4'h0, 4'hF, 4'hF, 0, 64'h0, 64'h0, 4'hF, 4'hF, 1, 0));
        step("reset_while_stalled", 1, 1, 0, 1, 1, 4'h6, 4'h1, 4'h3, 0, 64'h2A, 64'h0,
             mk(1, 4'h1, 4'hF, 4'hF, 0, 64'h0, 64'h0, 4'hF, 4'hF, 0, 0));
        step("ret_ins", 0, 0, 0, 4, 4, 4'h9, 4'h3, 4'h3, 1, 64'h40, 64'h41,
             mk(4, 4'h1, 4'hF, 4'hF, 1, 64'h40, 64'h41, 4'hF, 4'hF, 1, 0));

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected snapshots never checked, required 0",
                     exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
